nibble_pair_packer: RTL and testbench

NIBBLE_PAIR_PACKER -- requirements
Module: nibble_pair_packer

---
 rtl/nibble_pair_packer.sv | 101 ++++++++++
 tb/tb_nibble_pair_packer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_pair_packer.sv
// nibble_pair_packer: packs {hi, lo} nibble pairs into bytes and buffers them
// in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It also
// keeps a running count of accepted pairs and a sticky flag for offers that
// arrived while the buffer was full.
module nibble_pair_packer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_hi,
  input  logic [3:0]               in_lo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               accepted,
  output logic                     drop_seen,
  input  logic                     clr_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [7:0]    accepted_nxt;
  logic          drop_seen_nxt;
  logic          push;
  logic          pop;

  // Handshake status comes from registered state only; no full-with-pop bypass.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head of the FIFO; forced to zero while empty so unwritten storage never shows.
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  // Next-state computation for pointers, occupancy, counters and drop flag.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    accepted_nxt  = accepted;
    drop_seen_nxt = drop_seen;

    if (push) begin
      wr_ptr_nxt   = wr_ptr + AW'(1);
      accepted_nxt = accepted + 8'd1;
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    // A new drop outranks a simultaneous clear.
    if (in_valid && !in_ready) begin
      drop_seen_nxt = 1'b1;
    end else if (clr_drop) begin
      drop_seen_nxt = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      accepted  <= 8'h00;
      drop_seen <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      accepted  <= accepted_nxt;
      drop_seen <= drop_seen_nxt;
    end
  end

  // Byte storage; contents are qualified by count so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem[wr_ptr] <= {in_hi, in_lo};
    end
  end

endmodule

// File: tb/tb_nibble_pair_packer.sv
// Self-checking bench for nibble_pair_packer: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_nibble_pair_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_hi;
  logic [3:0]    in_lo;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] count;
  logic [7:0]    accepted;
  logic          drop_seen;
  logic          clr_drop;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_acc;
  bit         m_drop;
  bit         pristine;

  nibble_pair_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .accepted  (accepted),
    .drop_seen (drop_seen),
    .clr_drop  (clr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_acc    = 0;
    m_drop   = 1'b0;
    pristine = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},     16'(count),     16'(mq.size()));
    check({tag, ".out_valid"}, 16'(out_valid), 16'(mq.size() != 0));
    check({tag, ".in_ready"},  16'(in_ready),  16'(mq.size() < DEPTH));
    check({tag, ".accepted"},  16'(accepted),  16'(m_acc % 256));
    check({tag, ".drop_seen"}, 16'(drop_seen), 16'(m_drop));
    if (mq.size() != 0)
      check({tag, ".out_data"}, 16'(out_data), 16'(mq[0]));
    else if (pristine)
      check({tag, ".out_data_empty"}, 16'(out_data), 16'h0000);
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input bit ordy, input bit clr);
    in_valid  = v;
    in_hi     = b[7:4];
    in_lo     = b[3:0];
    out_ready = ordy;
    clr_drop  = clr;
  endtask

  // One clock: model sees the inputs presented before the edge, then outputs are compared.
  task automatic cycle(input string tag);
    bit         full;
    bit         push;
    bit         pop;
    logic [7:0] b;
    full = (mq.size() == DEPTH);
    push = in_valid && !full;
    pop  = out_ready && (mq.size() != 0);
    b    = {in_hi, in_lo};
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(b);
      m_acc++;
      pristine = 1'b0;
    end
    if (in_valid && full) m_drop = 1'b1;
    else if (clr_drop)    m_drop = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'h1F; exp_bytes[1] = 8'h2F; exp_bytes[2] = 8'h3F; exp_bytes[3] = 8'h4F;

    // Reset
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_hold");
    rst_n = 1'b1;

    // Single push, one-cycle latency, first edge after release
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("push_a5");
    check("a5.out_data", 16'(out_data), 16'h00A5);
    check("a5.count",    16'(count),    16'd1);
    check("a5.accepted", 16'(accepted), 16'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pop_a5");

    // Fill, drop attempt, ordered drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {4'(i + 1), 4'hF}, 1'b0, 1'b0);
      cycle("fill");
    end
    check("full.in_ready", 16'(in_ready), 16'd0);
    drive(1'b1, 8'h5F, 1'b0, 1'b0);
    cycle("drop5");
    check("drop5.drop_seen", 16'(drop_seen), 16'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain.byte", 16'(out_data), 16'(exp_bytes[i]));
      cycle("drain");
    end

    // Clear the flag, then collide a new drop with a clear
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cycle("clr_initial");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle("fill2");
    end
    drive(1'b1, 8'($urandom), 1'b0, 1'b1);
    cycle("set_vs_clr");
    check("set_wins", 16'(drop_seen), 16'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cycle("clr_only");
    check("clr_only.drop_seen", 16'(drop_seen), 16'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle("drain2");
    end

    // Steady stream at count=1 wraps both pointers
    drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle("stream_prime");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      cycle("stream");
      check("stream.count1", 16'(count), 16'd1);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      cycle("random");
    end

    // Build count=3, then reset mid-cycle
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle("predrain");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      cycle("pre_reset");
    end
    check("pre_reset.count3", 16'(count), 16'd3);
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.count",     16'(count),     16'd0);
    check("midrst.out_valid", 16'(out_valid), 16'd0);
    check("midrst.accepted",  16'(accepted),  16'd0);
    check_all("midrst");
    @(posedge clk); #1;
    check_all("midrst_hold");
    rst_n = 1'b1;

    // 256 pushes with continuous pop; the first byte after reset leads
    drive(1'b1, 8'hC3, 1'b1, 1'b0);
    cycle("post_rst_first");
    check("post_rst.first", 16'(out_data), 16'h00C3);
    for (int i = 1; i < 256; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      cycle("wrap256");
    end
    check("wrap256.accepted",  16'(accepted),  16'd0);
    check("wrap256.drop_seen", 16'(drop_seen), 16'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cycle("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
